// File: rtl/sgmii_an_rx.sv
// SGMII receive-side auto-negotiation: parses /C/ and /I/ ordered sets from the
// decoded character stream, tracks ability/acknowledge/idle matches and runs the AN state machine.
module sgmii_an_rx #(
    parameter int MATCH_COUNT = 3,
    parameter int LINK_TIMER  = 1600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_is_k,
    input  logic        rx_valid,
    input  logic        rx_code_err,
    output logic [15:0] lp_config,
    output logic        ability_match,
    output logic        ack_match,
    output logic        an_complete,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        duplex,
    output logic        rx_config_active
);
    localparam int CW = $clog2(MATCH_COUNT + 1);
    localparam int TW = $clog2(LINK_TIMER + 1);
    localparam logic [CW-1:0] MC = CW'(MATCH_COUNT);

    typedef enum logic [1:0] {P_COMMA, P_SECOND, P_CFG_LO, P_CFG_HI} p_state_t;
    typedef enum logic [2:0] {
        AN_IDLE, AN_ABILITY, AN_ACK, AN_LINK_TIMER, AN_WAIT_IDLE, AN_COMPLETE
    } an_state_t;

    p_state_t        p_q, p_d;
    an_state_t       an_q, an_d;
    logic [7:0]      lo_q, lo_d;
    logic [15:0]     prev_q, prev_d;
    logic [15:0]     lp_q, lp_d;
    logic [CW-1:0]   abil_cnt_q, abil_cnt_d;
    logic [CW-1:0]   ack_cnt_q, ack_cnt_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [2:0]      hist_q, hist_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            an_complete_q, an_complete_d;

    logic            is_comma, cfg_done, idle_done, clr;
    logic            ability_m, ack_m, idle_m;
    logic [15:0]     word;

    // Bit 14 is the acknowledge bit and is excluded from ability comparisons.
    function automatic logic [15:0] strip_ack(input logic [15:0] w);
        return w & 16'hBFFF;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == MC) ? c : c + 1'b1;
    endfunction

    assign ability_m = (abil_cnt_q == MC);
    assign ack_m     = ability_m && (ack_cnt_q == MC);
    assign idle_m    = (idle_cnt_q == MC);
    assign is_comma  = rx_is_k && (rx_data == 8'hBC);
    assign word      = {rx_data, lo_q};

    always_comb begin
        p_d        = p_q;
        lo_d       = lo_q;
        cfg_done   = 1'b0;
        idle_done  = 1'b0;
        clr        = 1'b0;
        if (rx_valid) begin
            if (rx_code_err) begin
                p_d = P_COMMA;
                clr = 1'b1;
            end else begin
                case (p_q)
                    P_COMMA:  if (is_comma) p_d = P_SECOND;
                    P_SECOND: begin
                        p_d = P_COMMA;
                        if (!rx_is_k && (rx_data == 8'hB5 || rx_data == 8'h42))
                            p_d = P_CFG_LO;
                        else if (!rx_is_k && (rx_data == 8'hC5 || rx_data == 8'h50))
                            idle_done = 1'b1;
                    end
                    P_CFG_LO: begin
                        if (rx_is_k) begin
                            clr = 1'b1;
                            p_d = is_comma ? P_SECOND : P_COMMA;
                        end else begin
                            lo_d = rx_data;
                            p_d  = P_CFG_HI;
                        end
                    end
                    default: begin
                        if (rx_is_k) begin
                            clr = 1'b1;
                            p_d = is_comma ? P_SECOND : P_COMMA;
                        end else begin
                            cfg_done = 1'b1;
                            p_d      = P_COMMA;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        prev_d     = prev_q;
        lp_d       = lp_q;
        abil_cnt_d = abil_cnt_q;
        ack_cnt_d  = ack_cnt_q;
        idle_cnt_d = idle_cnt_q;
        hist_d     = hist_q;
        an_d       = an_q;
        timer_d    = timer_q;
        if (clr) begin
            abil_cnt_d = '0;
            ack_cnt_d  = '0;
            idle_cnt_d = '0;
        end else if (cfg_done) begin
            prev_d     = word;
            abil_cnt_d = (strip_ack(word) == strip_ack(prev_q)) ? sat_inc(abil_cnt_q) : CW'(1);
            ack_cnt_d  = word[14] ? sat_inc(ack_cnt_q) : '0;
            idle_cnt_d = '0;
            hist_d     = {hist_q[1:0], 1'b1};
            if (abil_cnt_d == MC && abil_cnt_q != MC)
                lp_d = strip_ack(word);
        end else if (idle_done) begin
            idle_cnt_d = sat_inc(idle_cnt_q);
            hist_d     = {hist_q[1:0], 1'b0};
        end

        case (an_q)
            AN_IDLE:       if (ability_m && lp_q != 16'h0000) an_d = AN_ABILITY;
            AN_ABILITY:    if (ack_m) an_d = AN_ACK;
            AN_ACK: begin
                timer_d = TW'(LINK_TIMER - 1);
                an_d    = AN_LINK_TIMER;
            end
            AN_LINK_TIMER: begin
                if (timer_q == '0) an_d = AN_WAIT_IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            AN_WAIT_IDLE:  if (idle_m) an_d = AN_COMPLETE;
            default:       ;
        endcase

        // Word-driven restarts override the normal progression.
        if (cfg_done) begin
            if (an_q != AN_IDLE && word == 16'h0000) begin
                an_d = AN_IDLE;
                lp_d = 16'h0000;
            end else if ((an_q == AN_LINK_TIMER || an_q == AN_WAIT_IDLE) &&
                         strip_ack(word) != lp_q) begin
                an_d = AN_IDLE;
            end else if (an_q == AN_COMPLETE) begin
                an_d = AN_IDLE;
            end
        end
        an_complete_d = (an_d == AN_COMPLETE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_q           <= P_COMMA;
            an_q          <= AN_IDLE;
            lo_q          <= '0;
            prev_q        <= '0;
            lp_q          <= '0;
            abil_cnt_q    <= '0;
            ack_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            hist_q        <= '0;
            timer_q       <= '0;
            an_complete_q <= 1'b0;
        end else begin
            p_q           <= p_d;
            an_q          <= an_d;
            lo_q          <= lo_d;
            prev_q        <= prev_d;
            lp_q          <= lp_d;
            abil_cnt_q    <= abil_cnt_d;
            ack_cnt_q     <= ack_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            hist_q        <= hist_d;
            timer_q       <= timer_d;
            an_complete_q <= an_complete_d;
        end
    end

    assign lp_config        = lp_q;
    assign ability_match    = ability_m;
    assign ack_match        = ack_m;
    assign an_complete      = an_complete_q;
    assign link_up          = an_complete_q & lp_q[15];
    assign speed            = lp_q[11:10];
    assign duplex           = lp_q[12];
    assign rx_config_active = |hist_q;
endmodule

// File: tb/tb_sgmii_an_rx.sv
// Directed bench for sgmii_an_rx: drives ordered sets at the falling edge and
// compares outputs against hand-derived values at the following falling edge.
module tb_sgmii_an_rx;
    localparam int MC = 3;
    localparam int LT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_is_k = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_code_err = 1'b0;
    logic [15:0] lp_config;
    logic        ability_match, ack_match, an_complete, link_up, duplex, rx_config_active;
    logic [1:0]  speed;

    int checks = 0;
    int errors = 0;

    sgmii_an_rx #(.MATCH_COUNT(MC), .LINK_TIMER(LT)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_is_k(rx_is_k),
        .rx_valid(rx_valid), .rx_code_err(rx_code_err), .lp_config(lp_config),
        .ability_match(ability_match), .ack_match(ack_match), .an_complete(an_complete),
        .link_up(link_up), .speed(speed), .duplex(duplex), .rx_config_active(rx_config_active)
    );

    always #4 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic k, input logic [7:0] d, input logic err, input logic v);
        @(negedge clock);
        rx_is_k     = k;
        rx_data     = d;
        rx_code_err = err;
        rx_valid    = v;
    endtask

    task automatic gap(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_cfg(input logic [15:0] w);
        tick(1'b1, 8'hBC, 1'b0, 1'b1);
        tick(1'b0, 8'hB5, 1'b0, 1'b1);
        tick(1'b0, w[7:0], 1'b0, 1'b1);
        tick(1'b0, w[15:8], 1'b0, 1'b1);
    endtask

    task automatic send_idle();
        tick(1'b1, 8'hBC, 1'b0, 1'b1);
        tick(1'b0, 8'h50, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        rx_valid = 1'b0;
        gap(2);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lp"}, lp_config, 16'h0000);
        check({tag, "_flags"}, {ability_match, ack_match, an_complete, link_up,
                                duplex, rx_config_active, speed}, 8'h00);
    endtask

    task automatic run_full(input string tag);
        repeat (3) send_cfg(16'h9801);
        gap(1);
        check({tag, "_abil"}, ability_match, 1'b1);
        check({tag, "_lp_abil"}, lp_config, 16'h9801);
        check({tag, "_ack0"}, ack_match, 1'b0);
        check({tag, "_cfg_act"}, rx_config_active, 1'b1);
        repeat (3) send_cfg(16'hD801);
        gap(1);
        check({tag, "_ack1"}, ack_match, 1'b1);
        check({tag, "_lp_ack"}, lp_config, 16'h9801);
        gap(LT + 5);
        check({tag, "_pre_idle"}, an_complete, 1'b0);
        repeat (3) send_idle();
        gap(3);
        check({tag, "_done"}, an_complete, 1'b1);
        check({tag, "_link"}, link_up, 1'b1);
        check({tag, "_speed"}, speed, 2'b10);
        check({tag, "_duplex"}, duplex, 1'b1);
        check({tag, "_lp_done"}, lp_config, 16'h9801);
        check({tag, "_cfg_act0"}, rx_config_active, 1'b0);
    endtask

    initial begin
        gap(2);
        check_all_zero("reset");
        reset = 1'b0;

        // Full negotiation, then partner restart with a single /C/ set.
        run_full("full");
        send_cfg(16'h9801);
        gap(1);
        check("restart_done", an_complete, 1'b0);
        check("restart_link", link_up, 1'b0);

        // Non-matching words never produce an ability match.
        do_reset();
        send_cfg(16'h9801);
        send_cfg(16'h9401);
        send_cfg(16'h9801);
        gap(1);
        check("nomatch_abil", ability_match, 1'b0);
        check("nomatch_lp", lp_config, 16'h0000);

        // Zero word during the link timer restarts negotiation.
        do_reset();
        repeat (3) send_cfg(16'h9801);
        repeat (3) send_cfg(16'hD801);
        gap(8);
        send_cfg(16'h0000);
        gap(1);
        check("zero_lp", lp_config, 16'h0000);
        check("zero_done", an_complete, 1'b0);
        check("zero_abil", ability_match, 1'b0);
        gap(LT + 5);
        repeat (3) send_idle();
        gap(3);
        check("zero_stays_idle", an_complete, 1'b0);

        // Code error in the high byte of the second word restarts counting.
        do_reset();
        send_cfg(16'h9801);
        tick(1'b1, 8'hBC, 1'b0, 1'b1);
        tick(1'b0, 8'hB5, 1'b0, 1'b1);
        tick(1'b0, 8'h01, 1'b0, 1'b1);
        tick(1'b0, 8'h98, 1'b1, 1'b1);
        repeat (2) send_cfg(16'h9801);
        gap(1);
        check("err_two_clean", ability_match, 1'b0);
        send_cfg(16'h9801);
        gap(1);
        check("err_three_clean", ability_match, 1'b1);
        check("err_lp", lp_config, 16'h9801);

        // K28.5 inside a config word drops it and clears the match counters.
        do_reset();
        repeat (2) send_cfg(16'h9801);
        tick(1'b1, 8'hBC, 1'b0, 1'b1);
        tick(1'b0, 8'hB5, 1'b0, 1'b1);
        tick(1'b1, 8'hBC, 1'b0, 1'b1);
        tick(1'b0, 8'hB5, 1'b0, 1'b1);
        tick(1'b0, 8'h01, 1'b0, 1'b1);
        tick(1'b0, 8'h98, 1'b0, 1'b1);
        send_cfg(16'h9801);
        gap(1);
        check("kchar_no_match", ability_match, 1'b0);
        send_cfg(16'h9801);
        gap(1);
        check("kchar_match", ability_match, 1'b1);

        // Reset mid link timer with activity, then a clean negotiation.
        do_reset();
        repeat (3) send_cfg(16'h9801);
        repeat (3) send_cfg(16'hD801);
        gap(10);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b1, 8'hBC, 1'b0, i[0]);
        check_all_zero("midreset");
        @(negedge clock);
        reset = 1'b0;
        rx_valid = 1'b0;
        run_full("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
